// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage_pkg
// Brief    : Shared definitions for the ALU operand stage (op enum, issue word).
// Revision : 1.0 - initial release
// ============================================================================
package alu_operand_stage_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;
   localparam int OP_W     = 4;
   localparam int NUM_REGS = 2**ADDR_W;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_XOR   = 4'd2,
      OP_CLR   = 4'd3,
      OP_AND   = 4'd4,
      OP_OR    = 4'd5,
      OP_INC   = 4'd6,
      OP_NOT   = 4'd7,
      OP_PASSA = 4'd8
   } op_e;

   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rb;
      logic [ADDR_W-1:0] rd;
      logic              we;
   } issue_t;

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Brief    : 2R1W register file with combinational debug read; reset clears all.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file
   import alu_operand_stage_pkg::*;
#(
   parameter int W = DATA_W,
   parameter int A = ADDR_W
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [A-1:0] i_raddr_a,
   output logic [W-1:0] o_rdata_a,
   input  logic [A-1:0] i_raddr_b,
   output logic [W-1:0] o_rdata_b,
   input  logic [A-1:0] i_dbg_addr,
   output logic [W-1:0] o_dbg_data,
   input  logic         i_we,
   input  logic [A-1:0] i_waddr,
   input  logic [W-1:0] i_wdata
);

   logic [W-1:0] r_mem [NUM_REGS];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a  = r_mem[i_raddr_a];
   assign o_rdata_b  = r_mem[i_raddr_b];
   assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : Operand fetch / EX register / writeback ahead of the ALU, with
//            back-to-back bypass. Optional ZeroFlag via macro ZERO_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int W   = DATA_W,
   parameter int A   = ADDR_W,
   parameter int OPW = OP_W
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           IssueValid,
   output logic           IssueReady,
   input  logic [OPW-1:0] IssueOp,
   input  logic [A-1:0]   IssueRa,
   input  logic [A-1:0]   IssueRb,
   input  logic [A-1:0]   IssueRd,
   input  logic           IssueWe,
   input  logic           Hold,
   output logic [W-1:0]   AluInA,
   output logic [W-1:0]   AluInB,
   output logic [OPW-1:0] AluOp,
   input  logic [W-1:0]   AluOut,
   output logic           ExValid,
   input  logic [A-1:0]   DbgAddr,
   output logic [W-1:0]   DbgData
`ifdef ZERO_FLAG_EN
   ,
   output logic           ZeroFlag
`endif
);

   issue_t       w_issue;
   logic         w_xfer;
   logic         w_wb;
   logic         w_byp_a;
   logic         w_byp_b;
   logic [W-1:0] w_rf_a;
   logic [W-1:0] w_rf_b;
   logic [W-1:0] w_opnd_a;
   logic [W-1:0] w_opnd_b;

   issue_t       r_ex;
   logic         r_ex_valid;
   logic [W-1:0] r_alu_a;
   logic [W-1:0] r_alu_b;

   assign w_issue = '{op: op_e'(IssueOp), ra: IssueRa, rb: IssueRb,
                      rd: IssueRd, we: IssueWe};

   assign IssueReady = !Hold;
   assign w_xfer     = IssueValid && !Hold;
   assign w_wb       = r_ex_valid && r_ex.we && !Hold;

   reg_file #(
      .W (W),
      .A (A)
   ) u_reg_file (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_raddr_a  (w_issue.ra),
      .o_rdata_a  (w_rf_a),
      .i_raddr_b  (w_issue.rb),
      .o_rdata_b  (w_rf_b),
      .i_dbg_addr (DbgAddr),
      .o_dbg_data (DbgData),
      .i_we       (w_wb),
      .i_waddr    (r_ex.rd),
      .i_wdata    (AluOut)
   );

   // The EX result is written on the same edge this issue loads, so forward it.
   assign w_byp_a  = r_ex_valid && r_ex.we && (r_ex.rd == w_issue.ra);
   assign w_byp_b  = r_ex_valid && r_ex.we && (r_ex.rd == w_issue.rb);
   assign w_opnd_a = w_byp_a ? AluOut : w_rf_a;
   assign w_opnd_b = w_byp_b ? AluOut : w_rf_b;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_ex       <= '0;
         r_ex_valid <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
      end else if (w_xfer) begin
         r_ex       <= w_issue;
         r_ex_valid <= 1'b1;
         r_alu_a    <= w_opnd_a;
         r_alu_b    <= w_opnd_b;
      end else if (!Hold) begin
         r_ex_valid <= 1'b0;
      end
   end

   assign AluInA  = r_alu_a;
   assign AluInB  = r_alu_b;
   assign AluOp   = r_ex.op;
   assign ExValid = r_ex_valid;

`ifdef ZERO_FLAG_EN
   logic r_zero_flag;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_zero_flag <= 1'b0;
      end else if (w_wb) begin
         r_zero_flag <= (AluOut == '0);
      end
   end

   assign ZeroFlag = r_zero_flag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a sequential-semantics model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       IssueValid = 1'b0;
   logic       IssueReady;
   logic [3:0] IssueOp = '0;
   logic [2:0] IssueRa = '0;
   logic [2:0] IssueRb = '0;
   logic [2:0] IssueRd = '0;
   logic       IssueWe = 1'b0;
   logic       Hold = 1'b0;
   logic [7:0] AluInA;
   logic [7:0] AluInB;
   logic [3:0] AluOp;
   logic [7:0] AluOut;
   logic       ExValid;
   logic [2:0] DbgAddr = '0;
   logic [7:0] DbgData;
`ifdef ZERO_FLAG_EN
   logic       ZeroFlag;
`endif

   int checks = 0;
   int errors = 0;

   alu_operand_stage dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .IssueValid (IssueValid),
      .IssueReady (IssueReady),
      .IssueOp    (IssueOp),
      .IssueRa    (IssueRa),
      .IssueRb    (IssueRb),
      .IssueRd    (IssueRd),
      .IssueWe    (IssueWe),
      .Hold       (Hold),
      .AluInA     (AluInA),
      .AluInB     (AluInB),
      .AluOp      (AluOp),
      .AluOut     (AluOut),
      .ExValid    (ExValid),
      .DbgAddr    (DbgAddr),
      .DbgData    (DbgData)
`ifdef ZERO_FLAG_EN
      ,
      .ZeroFlag   (ZeroFlag)
`endif
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_XOR:  return a ^ b;
         OP_CLR:  return 8'd0;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_INC:  return a + 8'd1;
         OP_NOT:  return ~a;
         default: return a;
      endcase
   endfunction

   // External combinational ALU
   assign AluOut = alu_f(AluOp, AluInA, AluInB);

   // Model: committed regfile plus at most one pending (executing) instruction
   logic [7:0] m_rf [8];
   logic       m_pv = 1'b0;
   logic       m_pwe = 1'b0;
   logic [2:0] m_prd = '0;
   logic [7:0] m_pres = '0;
   logic [7:0] m_a = '0;
   logic [7:0] m_b = '0;
   logic [3:0] m_op = '0;
   logic       m_zf = 1'b0;
   logic [7:0] m_na;
   logic [7:0] m_nb;
   bit         started = 1'b0;

   function automatic logic [7:0] arch(input logic [2:0] r);
      if (m_pv && m_pwe && m_prd == r) return m_pres;
      return m_rf[r];
   endfunction

   always @(posedge Clk) begin
      started = 1'b1;
      if (Reset) begin
         for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
         m_pv = 1'b0; m_pwe = 1'b0; m_a = 8'd0; m_b = 8'd0; m_op = 4'd0; m_zf = 1'b0;
      end else if (!Hold) begin
         m_na = arch(IssueRa);
         m_nb = arch(IssueRb);
         if (m_pv && m_pwe) begin
            m_rf[m_prd] = m_pres;
            m_zf = (m_pres == 8'd0);
         end
         if (IssueValid) begin
            m_a = m_na; m_b = m_nb; m_op = IssueOp;
            m_pv = 1'b1; m_pwe = IssueWe; m_prd = IssueRd;
            m_pres = alu_f(IssueOp, m_na, m_nb);
         end else begin
            m_pv = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (started) begin
         chk("ready", IssueReady, !Hold);
         chk("ex_valid", ExValid, m_pv);
         chk("alu_in_a", AluInA, m_a);
         chk("alu_in_b", AluInB, m_b);
         chk("alu_op", AluOp, m_op);
         chk("dbg_data", DbgData, m_rf[DbgAddr]);
`ifdef ZERO_FLAG_EN
         chk("zero_flag", ZeroFlag, m_zf);
`endif
      end
   end

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic iss(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] rd, input logic we);
      IssueValid = 1'b1; IssueOp = op; IssueRa = ra; IssueRb = rb; IssueRd = rd; IssueWe = we;
   endtask

   task automatic idle();
      IssueValid = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
      DbgAddr = a;
      #1;
      chk(nm, DbgData, exp);
   endtask

   task automatic mid();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      repeat (3) tick();
      mid();
      chk("rst_exv", ExValid, 0);
      chk("rst_a", AluInA, 0);
      Reset = 1'b0;

      // r1 = 5 via CLR + INC chain, then r2 = r1 + r1
      iss(OP_CLR, 0, 0, 1, 1); tick();
      repeat (5) begin iss(OP_INC, 1, 0, 1, 1); tick(); end
      iss(OP_ADD, 1, 1, 2, 1); tick(); idle();
      mid();
      chk("t1_a", AluInA, 5);
      chk("t1_b", AluInB, 5);
      chk("t1_op", AluOp, OP_ADD);
      tick();
      rd_chk("t1_r1", 1, 5);
      rd_chk("t1_r2", 2, 10);

      // r3 = 7, r4 = 2, then dependent SUB -> ADD back-to-back
      iss(OP_CLR, 0, 0, 3, 1); tick();
      repeat (7) begin iss(OP_INC, 3, 0, 3, 1); tick(); end
      iss(OP_CLR, 0, 0, 4, 1); tick();
      repeat (2) begin iss(OP_INC, 4, 0, 4, 1); tick(); end
      iss(OP_SUB, 3, 4, 5, 1); tick();
      iss(OP_ADD, 5, 5, 6, 1); tick(); idle();
      mid();
      chk("t2_a", AluInA, 5);
      chk("t2_b", AluInB, 5);
      tick();
      rd_chk("t2_r5", 5, 5);
      rd_chk("t2_r6", 6, 10);

      // Hold for 3 cycles with ADD r2 = r3 + r4 (9) in EX
      iss(OP_ADD, 3, 4, 2, 1); tick();
      Hold = 1'b1;
      iss(OP_INC, 2, 0, 2, 1);
      repeat (3) begin
         mid();
         chk("t3_ready", IssueReady, 0);
         chk("t3_exv", ExValid, 1);
         rd_chk("t3_r2_held", 2, 10);
         tick();
      end
      Hold = 1'b0;
      rd_chk("t3_r2_pre", 2, 10);
      tick(); idle();
      rd_chk("t3_r2_wb", 2, 9);
      chk("t3_inc_a", AluInA, 9);
      tick();
      rd_chk("t3_r2_inc", 2, 10);

      // Reset with a writing XOR in EX
      iss(OP_XOR, 3, 4, 7, 1); tick(); idle();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      mid();
      chk("t4_exv", ExValid, 0);
      chk("t4_a", AluInA, 0);
      chk("t4_b", AluInB, 0);
      chk("t4_op", AluOp, 0);
      rd_chk("t4_r7", 7, 0);
      rd_chk("t4_r3", 3, 0);

      // Non-writing op must not source the bypass
      iss(OP_INC, 4, 0, 4, 1); tick();
      iss(OP_NOT, 4, 0, 4, 0); tick();
      iss(OP_ADD, 4, 4, 5, 1); tick(); idle();
      mid();
      chk("t5_a", AluInA, 1);
      chk("t5_b", AluInB, 1);
      rd_chk("t5_r4", 4, 1);
      tick();
      rd_chk("t5_r5", 5, 2);

`ifdef ZERO_FLAG_EN
      iss(OP_SUB, 1, 1, 1, 1); tick(); idle(); tick();
      chk("t6_zf_set", ZeroFlag, 1);
      iss(OP_ADD, 4, 5, 6, 1); tick(); idle(); tick();
      chk("t6_zf_clr", ZeroFlag, 0);
      rd_chk("t6_r6", 6, 3);
      iss(OP_CLR, 0, 0, 1, 0); tick(); idle(); tick();
      chk("t6_zf_keep", ZeroFlag, 0);
`endif

      // Randomized traffic
      repeat (3000) begin
         Reset      = ($urandom_range(0, 99) == 0);
         Hold       = ($urandom_range(0, 4) == 0);
         IssueValid = ($urandom_range(0, 3) != 0);
         IssueOp    = 4'($urandom_range(0, 15));
         IssueRa    = 3'($urandom_range(0, 7));
         IssueRb    = 3'($urandom_range(0, 7));
         IssueRd    = 3'($urandom_range(0, 7));
         IssueWe    = ($urandom_range(0, 3) != 0);
         DbgAddr    = 3'($urandom_range(0, 7));
         tick();
      end
      Reset = 1'b0; Hold = 1'b0; idle();
      repeat (3) tick();
      mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
